// File: rtl/div3_serial_decoder.sv
// Bit-serial divide-by-3: recovers x from a received 3*x word, MSB first, one bit per clock.
// Also reports the remainder and a divisible flag, with valid/ready handshakes on both sides.
module div3_serial_decoder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [1:0]       remainder,
    output logic             divisible,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_quot;
    logic [1:0]       r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [2:0] w_t;
    logic       w_qbit;
    logic [1:0] w_rem_next;
    logic       w_last;

    // Long-division step: the partial remainder (0..2) with the next bit appended is 0..5.
    assign w_t        = {r_rem, r_sh[WIDTH-1]};
    assign w_qbit     = (w_t >= 3'd3);
    assign w_rem_next = w_qbit ? 2'(w_t - 3'd3) : w_t[1:0];
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sh        <= '0;
            r_quot      <= '0;
            r_rem       <= 2'd0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sh       <= in_data;
                        r_quot     <= '0;
                        r_rem      <= 2'd0;
                        r_cnt      <= '0;
                        r_state    <= SHIFT;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_sh   <= {r_sh[WIDTH-2:0], 1'b0};
                    r_quot <= {r_quot[WIDTH-2:0], w_qbit};
                    r_rem  <= w_rem_next;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign divisible = (r_rem == 2'd0);

endmodule
